// File: rtl/snake_pkg.sv
// ----------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake game grid datapath.
//   - Cell codes stored in the 16x16 grid RAM.
//   - Default grid geometry (width, height, coordinate width).
//   - Grid reader FSM state type.
// No ports: package only.
// ----------------------------------------------------------------------------
package snake_pkg;

   // Cell codes held in the grid RAM
   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_FOOD  = 2'b01;
   localparam logic [1:0] CELL_SNAKE = 2'b10;
   localparam logic [1:0] CELL_RSVD  = 2'b11;

   // Default grid geometry
   localparam int DEF_GRID_W  = 16;
   localparam int DEF_GRID_H  = 16;
   localparam int DEF_COORD_W = 4;

   // Grid reader FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/cell_fifo2.sv
// ----------------------------------------------------------------------------
// cell_fifo2
// Two-entry synchronous FIFO with occupancy output.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset (empties the FIFO)
//   push       in   write push_data this cycle (caller guarantees room,
//                   taking a same-cycle pop into account)
//   push_data  in   WIDTH-bit entry
//   pop        in   remove the head entry; ignored when empty
//   pop_data   out  head entry (valid when count != 0)
//   count      out  number of stored entries, 0..2
// ----------------------------------------------------------------------------
module cell_fifo2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [1:0]       count
);

   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] count_q;
   logic       do_pop;

   assign do_pop = pop && (count_q != 2'd0);

   // One register per slot; the write pointer selects which one loads
   for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      logic [WIDTH-1:0] slot_q;
      always_ff @(posedge clk) begin
         if (reset) begin
            slot_q <= '0;
         end else if (push && (wr_ptr_q == 1'(gi))) begin
            slot_q <= push_data;
         end
      end
   end

   assign pop_data = rd_ptr_q ? g_slot[1].slot_q : g_slot[0].slot_q;
   assign count    = count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/grid_reader.sv
// ----------------------------------------------------------------------------
// grid_reader
// Scans the game grid RAM once per start request, streams every cell with
// its coordinates over a valid/ready interface and gathers per-frame stats.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 pulse; begins a frame scan when idle
//   rd_en/rd_x/rd_y       grid RAM read request (data returns next cycle)
//   rd_data               cell code, valid one cycle after rd_en
//   out_valid/out_ready   beat handshake
//   out_x/out_y/out_cell  beat payload; out_last flags the final cell
//   busy                  scan in progress
//   done                  one-cycle pulse after the last beat handshakes
//   snake_count           snake cells in the last completed frame
//   food_found/food_x/y   first food cell (raster order) of that frame
// ----------------------------------------------------------------------------
module grid_reader
   import snake_pkg::*;
#(
   parameter int GRID_W  = DEF_GRID_W,
   parameter int GRID_H  = DEF_GRID_H,
   parameter int COORD_W = DEF_COORD_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               rd_en,
   output logic [COORD_W-1:0] rd_x,
   output logic [COORD_W-1:0] rd_y,
   input  logic [1:0]         rd_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [COORD_W-1:0] out_x,
   output logic [COORD_W-1:0] out_y,
   output logic [1:0]         out_cell,
   output logic               out_last,
   output logic               busy,
   output logic               done,
   output logic [8:0]         snake_count,
   output logic               food_found,
   output logic [COORD_W-1:0] food_x,
   output logic [COORD_W-1:0] food_y
);

   localparam int                 BEAT_W = 2 * COORD_W + 3;
   localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(GRID_W - 1);
   localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(GRID_H - 1);

   state_t             state_q, state_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;

   // Read in flight: coordinates travel alongside the RAM latency
   logic               inflight_q;
   logic [COORD_W-1:0] pend_x_q;
   logic [COORD_W-1:0] pend_y_q;
   logic               pend_last_q;

   // Working statistics for the frame being scanned
   logic [8:0]         wsnake_q;
   logic               wfood_q;
   logic [COORD_W-1:0] wfood_x_q;
   logic [COORD_W-1:0] wfood_y_q;

   // Published statistics
   logic [8:0]         snake_count_q;
   logic               food_found_q;
   logic [COORD_W-1:0] food_x_q;
   logic [COORD_W-1:0] food_y_q;
   logic               done_q;

   logic [BEAT_W-1:0]  push_beat;
   logic [BEAT_W-1:0]  head_beat;
   logic [1:0]         fifo_count;
   logic               handshake;
   logic [2:0]         occupancy;
   logic               issue_ok;
   logic               at_last_cell;
   logic               drain_exit;
   logic               start_accept;

   cell_fifo2 #(
      .WIDTH (BEAT_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (inflight_q),
      .push_data (push_beat),
      .pop       (out_ready),
      .pop_data  (head_beat),
      .count     (fifo_count)
   );

   assign push_beat = {pend_x_q, pend_y_q, rd_data, pend_last_q};

   assign out_valid = (fifo_count != 2'd0);
   assign out_x     = head_beat[BEAT_W-1 -: COORD_W];
   assign out_y     = head_beat[COORD_W+2 -: COORD_W];
   assign out_cell  = head_beat[2:1];
   assign out_last  = head_beat[0];
   assign handshake = out_valid && out_ready;

   // Slots held by stored beats plus the read in flight. The head leaving
   // this cycle frees its slot, which lets a read issue every cycle while
   // the consumer keeps up; the FIFO still cannot overflow.
   assign occupancy = {1'b0, fifo_count} - {2'b0, handshake} + {2'b0, inflight_q};
   assign issue_ok  = (occupancy < 3'd2);

   assign rd_en        = (state_q == SCAN) && issue_ok;
   assign rd_x         = x_q;
   assign rd_y         = y_q;
   assign at_last_cell = (x_q == X_MAX) && (y_q == Y_MAX);

   // Frame ends once the final beat leaves and no read is outstanding
   assign drain_exit = !inflight_q &&
                       ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && handshake));

   // A start coinciding with the done pulse is dropped
   assign start_accept = (state_q == IDLE) && start && !done_q;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      case (state_q)
         IDLE: begin
            if (start_accept) begin
               state_d = SCAN;
               x_d     = '0;
               y_d     = '0;
            end
         end
         SCAN: begin
            if (rd_en) begin
               if (x_q == X_MAX) begin
                  x_d = '0;
                  if (y_q == Y_MAX) begin
                     y_d     = '0;
                     state_d = DRAIN;
                  end else begin
                     y_d = y_q + 1'b1;
                  end
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (drain_exit) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         x_q           <= '0;
         y_q           <= '0;
         inflight_q    <= 1'b0;
         pend_x_q      <= '0;
         pend_y_q      <= '0;
         pend_last_q   <= 1'b0;
         wsnake_q      <= '0;
         wfood_q       <= 1'b0;
         wfood_x_q     <= '0;
         wfood_y_q     <= '0;
         snake_count_q <= '0;
         food_found_q  <= 1'b0;
         food_x_q      <= '0;
         food_y_q      <= '0;
         done_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         inflight_q  <= rd_en;
         if (rd_en) begin
            pend_x_q    <= x_q;
            pend_y_q    <= y_q;
            pend_last_q <= at_last_cell;
         end

         // Statistics follow the push into the FIFO, not the handshake
         if (start_accept) begin
            wsnake_q  <= '0;
            wfood_q   <= 1'b0;
            wfood_x_q <= '0;
            wfood_y_q <= '0;
         end else if (inflight_q) begin
            if (rd_data == CELL_SNAKE) begin
               wsnake_q <= wsnake_q + 9'd1;
            end
            if ((rd_data == CELL_FOOD) && !wfood_q) begin
               wfood_q   <= 1'b1;
               wfood_x_q <= pend_x_q;
               wfood_y_q <= pend_y_q;
            end
         end

         done_q <= (state_q == DRAIN) && drain_exit;
         if ((state_q == DRAIN) && drain_exit) begin
            snake_count_q <= wsnake_q;
            food_found_q  <= wfood_q;
            food_x_q      <= wfood_x_q;
            food_y_q      <= wfood_y_q;
         end
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign snake_count = snake_count_q;
   assign food_found  = food_found_q;
   assign food_x      = food_x_q;
   assign food_y      = food_y_q;

endmodule

// File: tb/tb_grid_reader.sv
// ----------------------------------------------------------------------------
// tb_grid_reader
// Frame scenarios from a table, randomized grids and backpressure, plus
// hand-written sequences for start-while-busy, start on done and reset
// mid-frame. A reference model built from the grid contents (raster-order
// beat queue and loop-computed statistics) checks every beat and frame.
// ----------------------------------------------------------------------------
module tb_grid_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       rd_en;
   logic [3:0] rd_x, rd_y;
   logic [1:0] rd_data = 2'b00;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_x, out_y;
   logic [1:0] out_cell;
   logic       out_last;
   logic       busy;
   logic       done;
   logic [8:0] snake_count;
   logic       food_found;
   logic [3:0] food_x, food_y;

   always #5 clk = ~clk;

   grid_reader dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .rd_en       (rd_en),
      .rd_x        (rd_x),
      .rd_y        (rd_y),
      .rd_data     (rd_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_x       (out_x),
      .out_y       (out_y),
      .out_cell    (out_cell),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done),
      .snake_count (snake_count),
      .food_found  (food_found),
      .food_x      (food_x),
      .food_y      (food_y)
   );

   // Grid RAM model, indexed [y][x], one-cycle read latency
   logic [1:0] grid [16][16];
   always @(posedge clk) begin
      if (rd_en) rd_data <= grid[rd_y][rd_x];
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input bit ok, input string name,
                      input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- reference model + monitor ----------------
   logic [10:0] exp_q[$];
   int   m_snake;
   bit   m_food;
   int   m_fx, m_fy;
   bit   active      = 0;
   int   ncyc        = 0;
   int   start_n     = 0;
   int   rd_idx      = 0;
   int   outstanding = 0;
   int   beat_cnt    = 0;
   int   done_cnt    = 0;
   int   frame_no    = 0;
   bit   timing_chk  = 0;
   bit   prev_stall  = 0;
   logic [10:0] prev_beat;

   task automatic build_model();
      exp_q.delete();
      m_snake = 0; m_food = 0; m_fx = 0; m_fy = 0;
      for (int y = 0; y < 16; y++) begin
         for (int x = 0; x < 16; x++) begin
            logic [3:0] bx, by;
            bx = 4'(x); by = 4'(y);
            exp_q.push_back({bx, by, grid[y][x], (x == 15 && y == 15)});
            if (grid[y][x] == 2'b10) m_snake++;
            if (grid[y][x] == 2'b01 && !m_food) begin
               m_food = 1; m_fx = x; m_fy = y;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      logic [10:0] beat_now;
      logic [10:0] e;
      bit hs;
      ncyc++;
      beat_now = {out_x, out_y, out_cell, out_last};
      if (reset) begin
         exp_q.delete();
         active      = 0;
         prev_stall  = 0;
         outstanding = 0;
      end else begin
         hs = out_valid && out_ready;
         if (prev_stall) begin
            chk(out_valid === 1'b1, "stall_valid", 32'(out_valid), 1);
            chk(beat_now === prev_beat, "stall_data", 32'(beat_now), 32'(prev_beat));
         end
         prev_stall = out_valid && !out_ready;
         prev_beat  = beat_now;
         if (rd_en) begin
            chk(active && rd_idx < 256, "rd_in_frame", 32'(rd_idx), 255);
            chk(outstanding - int'(hs) < 2, "rd_credit", 32'(outstanding - int'(hs)), 1);
            chk({rd_y, rd_x} == 8'(rd_idx), "rd_addr", 32'({rd_y, rd_x}), 32'(rd_idx & 255));
            rd_idx++;
         end
         outstanding = outstanding + int'(rd_en) - int'(hs);
         if (hs) begin
            if (exp_q.size() == 0) begin
               chk(0, "beat_unexpected", 32'(beat_now), 0);
            end else begin
               e = exp_q.pop_front();
               chk(beat_now === e, "beat", 32'(beat_now), 32'(e));
               if (beat_cnt == 0 && timing_chk)
                  chk(ncyc - start_n == 2, "first_beat_cycle", 32'(ncyc - start_n), 2);
               beat_cnt++;
            end
         end
         if (done) begin
            chk(active && exp_q.size() == 0, "done_expected", 32'(exp_q.size()), 0);
            chk(snake_count == 9'(m_snake), "snake_count", 32'(snake_count), 32'(m_snake));
            chk(food_found == m_food, "food_found", 32'(food_found), 32'(m_food));
            if (m_food) begin
               chk(food_x == 4'(m_fx), "food_x", 32'(food_x), 32'(m_fx));
               chk(food_y == 4'(m_fy), "food_y", 32'(food_y), 32'(m_fy));
            end
            if (timing_chk)
               chk(ncyc - start_n == 258, "done_cycle", 32'(ncyc - start_n), 258);
            $display("frame %0d done: beats=%0d snake=%0d food=%0d at (%0d,%0d)",
                     frame_no, beat_cnt, snake_count, food_found, food_x, food_y);
            done_cnt++;
            active = 0;
         end
         if (start && !busy && !done) begin
            build_model();
            active   = 1;
            start_n  = ncyc + 1;
            rd_idx   = 0;
            beat_cnt = 0;
            frame_no++;
         end
      end
   end

   // ---------------- out_ready driver ----------------
   int ready_mode = 0;   // 0: always, 1: ~50% random, 2: random + 20-cycle stall
   int stall_left = 0;
   bit stall_done = 0;

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom % 2);
            default: begin
               if (stall_left > 0) begin
                  out_ready = 1'b0;
                  stall_left--;
               end else if (!stall_done && beat_cnt >= 128) begin
                  out_ready  = 1'b0;
                  stall_left = 19;
                  stall_done = 1;
               end else begin
                  out_ready = 1'($urandom % 2);
               end
            end
         endcase
      end
   end

   // ---------------- stimulus ----------------
   typedef struct {
      string name;
      int    pattern;   // 0 empty,1 snake+food,2 all snake,3 random,4 all food,5 all reserved
      int    rmode;
      bit    use_model;
      int    snake;
      bit    food;
      int    fx;
      int    fy;
   } row_t;

   row_t rows[7];
   int   exp_done = 0;

   task automatic fill(input int pattern);
      for (int y = 0; y < 16; y++) begin
         for (int x = 0; x < 16; x++) begin
            case (pattern)
               0: grid[y][x] = 2'b00;
               1: grid[y][x] = 2'b00;
               2: grid[y][x] = 2'b10;
               3: grid[y][x] = ($urandom % 16 == 0) ? 2'b01 : 2'($urandom % 4 == 0 ? 2'b01 + 2'(1 + $urandom % 3) - 2'b01 : 2'b00);
               4: grid[y][x] = 2'b01;
               default: grid[y][x] = 2'b11;
            endcase
         end
      end
      if (pattern == 1) begin
         grid[2][3] = 2'b10; grid[2][4] = 2'b10; grid[2][5] = 2'b10;
         grid[7][9] = 2'b01; grid[12][1] = 2'b01;
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (done === 1'b1) break;
         @(posedge clk); #1;
      end
      chk(done === 1'b1, "done_timeout", 32'(done), 1);
      if (done === 1'b1) exp_done++;
   endtask

   initial begin
      int d_before;
      rows[0] = '{"empty",       0, 0, 0,   0, 0, 0, 0};
      rows[1] = '{"snake_food",  1, 0, 0,   3, 1, 9, 7};
      rows[2] = '{"all_snake",   2, 0, 0, 256, 0, 0, 0};
      rows[3] = '{"rand_bp",     3, 1, 1,   0, 0, 0, 0};
      rows[4] = '{"rand_stall",  3, 2, 1,   0, 0, 0, 0};
      rows[5] = '{"all_food",    4, 1, 0,   0, 1, 0, 0};
      rows[6] = '{"all_rsvd",    5, 0, 0,   0, 0, 0, 0};

      reset = 1'b1;
      start = 1'b0;
      fill(0);
      repeat (3) @(posedge clk);
      #1;
      chk(busy == 1'b0,        "rst_busy",   32'(busy), 0);
      chk(out_valid == 1'b0,   "rst_valid",  32'(out_valid), 0);
      chk(rd_en == 1'b0,       "rst_rd_en",  32'(rd_en), 0);
      chk(done == 1'b0,        "rst_done",   32'(done), 0);
      chk(snake_count == 9'd0, "rst_snake",  32'(snake_count), 0);
      chk(food_found == 1'b0,  "rst_food",   32'(food_found), 0);
      chk({food_x, food_y} == 8'd0, "rst_food_xy", 32'({food_x, food_y}), 0);
      reset = 1'b0;

      // Table-driven frames
      for (int r = 0; r < 7; r++) begin
         fill(rows[r].pattern);
         ready_mode = rows[r].rmode;
         stall_done = 0;
         timing_chk = (rows[r].rmode == 0);
         pulse_start();
         wait_done(3000);
         if (!rows[r].use_model) begin
            chk(snake_count == 9'(rows[r].snake), {rows[r].name, "_snake"},
                32'(snake_count), 32'(rows[r].snake));
            chk(food_found == rows[r].food, {rows[r].name, "_food"},
                32'(food_found), 32'(rows[r].food));
            chk({food_x, food_y} == {4'(rows[r].fx), 4'(rows[r].fy)}, {rows[r].name, "_food_xy"},
                32'({food_x, food_y}), 32'({4'(rows[r].fx), 4'(rows[r].fy)}));
         end
         repeat (2) @(posedge clk);
         #1;
      end

      // Extra start pulses during SCAN/DRAIN are ignored
      fill(1);
      ready_mode = 1;
      timing_chk = 0;
      d_before   = done_cnt;
      pulse_start();
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) break;
         start = 1'($urandom % 6 == 0);
      end
      chk(done === 1'b1, "busy_start_done", 32'(done), 1);
      if (done === 1'b1) exp_done++;

      // Start held in the done cycle is dropped; start the next cycle runs
      start = 1'b1;
      @(posedge clk); #1;
      chk(busy == 1'b0, "start_on_done_ignored", 32'(busy), 0);
      @(posedge clk); #1;
      start = 1'b0;
      chk(busy == 1'b1, "start_after_done", 32'(busy), 1);
      chk(done_cnt == d_before + 1, "one_done_per_frame", 32'(done_cnt), 32'(d_before + 1));
      wait_done(3000);
      repeat (2) @(posedge clk);
      #1;

      // Reset at beat 100 aborts the frame and clears the statistics
      ready_mode = 0;
      pulse_start();
      for (int i = 0; i < 1000; i++) begin
         if (beat_cnt >= 100) break;
         @(posedge clk); #1;
      end
      chk(beat_cnt >= 100, "reach_beat_100", 32'(beat_cnt), 100);
      d_before = done_cnt;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk(busy == 1'b0,        "rst_mid_busy",  32'(busy), 0);
      chk(out_valid == 1'b0,   "rst_mid_valid", 32'(out_valid), 0);
      chk(snake_count == 9'd0, "rst_mid_snake", 32'(snake_count), 0);
      chk(food_found == 1'b0,  "rst_mid_food",  32'(food_found), 0);
      repeat (5) @(posedge clk);
      #1;
      chk(done_cnt == d_before, "rst_mid_no_done", 32'(done_cnt), 32'(d_before));

      // Fresh frame after the abort scans from (0,0) with normal timing
      timing_chk = 1;
      pulse_start();
      wait_done(3000);
      chk(snake_count == 9'd3, "post_rst_snake", 32'(snake_count), 3);
      chk({food_x, food_y} == {4'd9, 4'd7}, "post_rst_food_xy",
          32'({food_x, food_y}), 32'({4'd9, 4'd7}));
      repeat (3) @(posedge clk);
      #1;
      chk(done_cnt == exp_done, "done_total", 32'(done_cnt), 32'(exp_done));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
